// File: rtl/my_rom_loader.sv
// rtl/my_rom_loader.sv - boot loader filling instruction ROM from a checksummed byte stream
// Holds the CPU in reset until LEN big-endian words plus a zero-sum CHK byte have arrived.
module my_rom_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_WORDS  = 32768
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  rom_wr_en,
  output logic [ADDR_WIDTH-1:0] rom_wr_addr,
  output logic [15:0]           rom_wr_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  hi_byte;
  logic [7:0]  sum;
  logic [15:0] len;
  logic [15:0] word_cnt;

  logic        xfer;
  logic [15:0] byte_pair;
  logic [7:0]  sum_nxt;

  assign xfer      = in_valid && in_ready;
  assign byte_pair = {hi_byte, in_data};
  assign sum_nxt   = sum + in_data;

  // Status outputs are registered together with the state they describe.
  task automatic go(input state_t s);
    state     <= s;
    in_ready  <= (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
                 (s == S_DATA_LO) || (s == S_CHECK);
    busy      <= (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
                 (s == S_DATA_LO) || (s == S_CHECK);
    cpu_reset <= (s != S_DONE);
  endtask

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      rom_wr_en   <= 1'b0;
      rom_wr_addr <= '0;
      rom_wr_data <= '0;
      hi_byte     <= '0;
      sum         <= '0;
      len         <= '0;
      word_cnt    <= '0;
    end else begin
      rom_wr_en <= 1'b0;
      // Advance only while words remain, so the address never wraps past the last one.
      if (rom_wr_en && (word_cnt != len))
        rom_wr_addr <= rom_wr_addr + 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            go(S_LEN_HI);
            done        <= 1'b0;
            error       <= 1'b0;
            sum         <= '0;
            word_cnt    <= '0;
            rom_wr_addr <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            sum     <= sum_nxt;
            go(S_LEN_LO);
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= byte_pair;
            sum <= sum_nxt;
            if ({1'b0, byte_pair} > MAX_LEN) begin
              error <= 1'b1;
              go(S_ERROR);
            end else if (byte_pair == 16'd0) begin
              go(S_CHECK);
            end else begin
              go(S_DATA_HI);
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            sum     <= sum_nxt;
            go(S_DATA_LO);
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            rom_wr_en   <= 1'b1;
            rom_wr_data <= byte_pair;
            word_cnt    <= word_cnt + 16'd1;
            sum         <= sum_nxt;
            if (word_cnt + 16'd1 == len) go(S_CHECK);
            else                         go(S_DATA_HI);
          end
        end
        S_CHECK: begin
          if (xfer) begin
            sum <= sum_nxt;
            if (sum_nxt == 8'h00) begin
              done <= 1'b1;
              go(S_DONE);
            end else begin
              error <= 1'b1;
              go(S_ERROR);
            end
          end
        end
        default: go(S_IDLE);
      endcase
    end
  end

endmodule

// File: tb/tb_my_rom_loader.sv
// tb/tb_my_rom_loader.sv - directed scoreboard bench for my_rom_loader
module tb_my_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_wr_en;
  logic [14:0] rom_wr_addr;
  logic [15:0] rom_wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  my_rom_loader #(.ADDR_WIDTH(15), .MAX_WORDS(32768)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_wr_en(rom_wr_en), .rom_wr_addr(rom_wr_addr),
    .rom_wr_data(rom_wr_data), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         failures = 0;
  int         n_writes = 0;
  int         w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected word in order.
  always @(negedge clk) begin
    if (reset === 1'b1 && rom_wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(rom_wr_addr), 32'hffff_ffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rom_wr_addr), 32'(e.addr));
        chk("wr_data", 32'(rom_wr_data), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input bit gaps);
    for (int i = 0; i < stim.size(); i++) begin
      if (gaps) begin
        int g;
        g = (i % 2 == 0) ? 1 : int'($urandom_range(1, 4));
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      send_byte(stim[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_done_ok(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state and idle without start
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(rom_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(rom_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(rom_wr_data), 32'd0);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_error", 32'(error), 32'd0);
    chk("idle_writes", 32'(n_writes), 32'd0);

    // 2: good two-word image, back-to-back
    w0 = n_writes;
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    exp_q.push_back('{addr: 15'd1, data: 16'hABCD});
    do_start();
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_stream(0);
    check_done_ok("t2");
    chk("t2_writes", 32'(n_writes - w0), 32'd2);

    // 3: bad checksum, words still written, restart clears error
    w0 = n_writes;
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    exp_q.push_back('{addr: 15'd1, data: 16'hABCD});
    do_start();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_stream(0);
    repeat (2) @(negedge clk);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t3_writes", 32'(n_writes - w0), 32'd2);
    do_start();
    chk("t3_restart_error", 32'(error), 32'd0);
    chk("t3_restart_in_ready", 32'(in_ready), 32'd1);

    // 4: oversize length from the pending start, then empty image
    w0 = n_writes;
    stim = '{8'h80, 8'h01};
    send_stream(0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_writes", 32'(n_writes - w0), 32'd0);
    do_start();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    check_done_ok("t4_empty");
    chk("t4_empty_writes", 32'(n_writes - w0), 32'd0);

    // 5: same image with valid gaps
    w0 = n_writes;
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    exp_q.push_back('{addr: 15'd1, data: 16'hABCD});
    do_start();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_stream(1);
    check_done_ok("t5");
    chk("t5_writes", 32'(n_writes - w0), 32'd2);

    // 6: reset mid-load drops the pending second write
    w0 = n_writes;
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    do_start();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_stream(0);
    in_data = 8'hCD; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_pending_wr_en", 32'(rom_wr_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_abort_wr_en", 32'(rom_wr_en), 32'd0);
    chk("t6_abort_addr", 32'(rom_wr_addr), 32'd0);
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_abort_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_partial_writes", 32'(n_writes - w0), 32'd1);
    chk("t6_partial_queue", 32'(exp_q.size()), 32'd0);
    w0 = n_writes;
    exp_q.push_back('{addr: 15'd0, data: 16'h1234});
    exp_q.push_back('{addr: 15'd1, data: 16'hABCD});
    do_start();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_stream(0);
    check_done_ok("t6_reload");
    chk("t6_reload_writes", 32'(n_writes - w0), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
